rs_issue_scheduler: RTL and testbench
=====================================

Name: rs_issue_scheduler

Overview:
- Age-ordered reservation-station scheduler between dispatch and the functional units.
- Buffers up to RS_DEPTH dispatched uops and tracks source readiness through writeback-tag wakeup.
- Each cycle, selects the oldest ready entry and presents it to the FU with a valid/ready handshake.
- Entry contents mirror the team's rs_data fields: valid, Opcode, prd, pr1, pr1_ready, pr2, pr2_ready, imm, rob_index, age.

Parameters:
- RS_DEPTH, 8, number of entries; the age field is clog2(RS_DEPTH) bits (3 at default).
- PREG_W, 7, physical register tag width.
- ROB_W, 4, ROB index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_opcode  in  7  uop opcode.
- disp_prd  in  PREG_W  destination physical register.
- disp_pr1, disp_pr2  in  PREG_W  source physical registers.
- disp_pr1_ready, disp_pr2_ready  in  1  source already available.
- disp_imm  in  32  immediate.
- disp_rob_index  in  ROB_W  ROB slot.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  PREG_W  physical register being written.
- issue_valid  out  1  selected entry is presented.
- issue_ready  in  1  FU accepts the uop.
- issue_opcode  out  7  opcode of the selected entry.
- issue_prd, issue_pr1, issue_pr2  out  PREG_W  register tags of the selected entry.
- issue_imm  out  32  immediate of the selected entry.
- issue_rob_index  out  ROB_W  ROB slot of the selected entry.
- occupancy  out  clog2(RS_DEPTH)+1  count of valid entries.

Behaviour:
- Reset: all entry valid bits, ready bits and ages clear. Resulting outputs: occupancy=0, disp_ready=1, issue_valid=0; all issue_* data outputs drive 0 when issue_valid=0.
- Dispatch handshake: accept when disp_valid && disp_ready.
  - disp_ready = (occupancy < RS_DEPTH); computed from registered state only.
  - An issue in the same cycle does not create a free slot until the next cycle.
- Allocation: the lowest-index free entry is written.
  - The new entry gets age 0; every other valid entry's age increments, saturating at RS_DEPTH-1.
  - Ages of valid entries are therefore unique; larger age means older.
- Operand ready on allocation: set if disp_prN_ready, or disp_prN==0 (p0 is always ready), or (wb_valid && wb_tag==disp_prN) in the same cycle.
- Wakeup: on wb_valid, every valid entry whose pr1 or pr2 equals wb_tag sets the matching ready bit at the edge.
  - Without bypass, the woken entry is selectable the following cycle (1-cycle wakeup-to-select).
- Select: combinational over registered state.
  - Eligible entry: valid && pr1_ready && pr2_ready.
  - Winner is the eligible entry with maximum age; ties (not expected) go to the lowest index.
  - issue_valid = any eligible && !flush.
- Issue: on issue_valid && issue_ready, the winner's valid bit clears at the edge.
  - While issue_ready=0, the outputs hold the same winner, unless an older entry becomes eligible.
  - The outputs need not stay stable while stalled; the FU samples only on handshake.
- Simultaneous dispatch and issue: both take effect. Occupancy is unchanged, and the freed entry may not be reused in that same cycle.
- Flush: has priority over all other events.
  - All valid bits clear at the edge.
  - Dispatch and wakeup are ignored that cycle; issue_valid is forced 0.
  - Next cycle: occupancy=0, disp_ready=1.
- Reset asserted mid-operation behaves like flush and also clears ages; reset takes priority over flush.
- Occupancy is a registered counter: +1 on accept, -1 on issue, unchanged when both occur, 0 after flush or reset. It never exceeds RS_DEPTH and never goes below 0.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined: an entry whose missing operand matches (wb_valid && wb_tag) in the current cycle is eligible for select that same cycle (0-cycle wakeup-to-select). The ready bit is still set at the edge.
- Undefined: the 1-cycle wakeup-to-select latency described above.

Test Plan:
- Reset, then idle -> occupancy=0, disp_ready=1, issue_valid=0, all issue_* outputs=0.
- Dispatch 8 uops (rob_index 0..7, all ready), issue_ready=0 -> occupancy=8, disp_ready=0, a 9th disp_valid is not accepted; then issue_ready=1 -> issue order rob_index 0,1,...,7 over 8 cycles.
- Dispatch A (pr1=20 not ready) then B (ready) -> B issues first. Then wb_valid with wb_tag=20 at cycle t -> A issue_valid at t+1; with RS_WAKEUP_BYPASS_EN, at t.
- Dispatch with disp_pr2=35 not ready while wb_valid, wb_tag=35 in the same cycle -> entry captured ready, issues the next cycle.
- Full RS, same-cycle issue handshake and disp_valid -> dispatch not accepted; next cycle occupancy=7, disp_ready=1.
- 5 entries held, flush asserted together with disp_valid and wb_valid -> issue_valid=0 that cycle; next cycle occupancy=0 and no stale issue afterwards.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - age-ordered reservation station: dispatch, tag wakeup, oldest-ready issue
// Optional macro RS_WAKEUP_BYPASS_EN: same-cycle writeback wakeup feeds select (0-cycle wakeup-to-select).
module rs_issue_scheduler #(
    parameter int RS_DEPTH = 8,
    parameter int PREG_W   = 7,
    parameter int ROB_W    = 4,
    localparam int AGE_W   = $clog2(RS_DEPTH),
    localparam int OCC_W   = $clog2(RS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [6:0]        disp_opcode,
    input  logic [PREG_W-1:0] disp_prd,
    input  logic [PREG_W-1:0] disp_pr1,
    input  logic [PREG_W-1:0] disp_pr2,
    input  logic              disp_pr1_ready,
    input  logic              disp_pr2_ready,
    input  logic [31:0]       disp_imm,
    input  logic [ROB_W-1:0]  disp_rob_index,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_tag,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [6:0]        issue_opcode,
    output logic [PREG_W-1:0] issue_prd,
    output logic [PREG_W-1:0] issue_pr1,
    output logic [PREG_W-1:0] issue_pr2,
    output logic [31:0]       issue_imm,
    output logic [ROB_W-1:0]  issue_rob_index,
    output logic [OCC_W-1:0]  occupancy
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RS_DEPTH - 1);

    logic [RS_DEPTH-1:0] r_valid;
    logic [RS_DEPTH-1:0] r_pr1_rdy;
    logic [RS_DEPTH-1:0] r_pr2_rdy;
    logic [6:0]          r_opcode [RS_DEPTH];
    logic [PREG_W-1:0]   r_prd    [RS_DEPTH];
    logic [PREG_W-1:0]   r_pr1    [RS_DEPTH];
    logic [PREG_W-1:0]   r_pr2    [RS_DEPTH];
    logic [31:0]         r_imm    [RS_DEPTH];
    logic [ROB_W-1:0]    r_rob    [RS_DEPTH];
    logic [AGE_W-1:0]    r_age    [RS_DEPTH];
    logic [OCC_W-1:0]    r_occ;

    logic [RS_DEPTH-1:0] w_rdy1;
    logic [RS_DEPTH-1:0] w_rdy2;
    logic [RS_DEPTH-1:0] w_elig;
    logic                w_any;
    logic [AGE_W-1:0]    w_win_idx;
    logic [AGE_W-1:0]    w_win_age;
    logic                w_free_found;
    logic [AGE_W-1:0]    w_free_idx;
    logic                w_accept;
    logic                w_fire;
    logic                w_new_rdy1;
    logic                w_new_rdy2;

    always_comb begin
        w_rdy1 = '0;
        w_rdy2 = '0;
        w_elig = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            w_rdy1[i] = r_pr1_rdy[i] | (wb_valid && (wb_tag == r_pr1[i]));
            w_rdy2[i] = r_pr2_rdy[i] | (wb_valid && (wb_tag == r_pr2[i]));
`else
            w_rdy1[i] = r_pr1_rdy[i];
            w_rdy2[i] = r_pr2_rdy[i];
`endif
            w_elig[i] = r_valid[i] & w_rdy1[i] & w_rdy2[i];
        end
    end

    // Oldest eligible wins; strict compare keeps the lowest index on an age tie.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_age = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_elig[i] && (!w_any || (r_age[i] > w_win_age))) begin
                w_any     = 1'b1;
                w_win_idx = AGE_W'(i);
                w_win_age = r_age[i];
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = AGE_W'(i);
            end
        end
    end

    assign disp_ready  = (r_occ < OCC_W'(RS_DEPTH));
    assign issue_valid = w_any && !flush;
    assign occupancy   = r_occ;
    assign w_accept    = disp_valid && disp_ready && w_free_found;
    assign w_fire      = issue_valid && issue_ready;
    assign w_new_rdy1  = disp_pr1_ready || (disp_pr1 == '0) || (wb_valid && (wb_tag == disp_pr1));
    assign w_new_rdy2  = disp_pr2_ready || (disp_pr2 == '0) || (wb_valid && (wb_tag == disp_pr2));

    always_comb begin
        issue_opcode    = '0;
        issue_prd       = '0;
        issue_pr1       = '0;
        issue_pr2       = '0;
        issue_imm       = '0;
        issue_rob_index = '0;
        if (issue_valid) begin
            issue_opcode    = r_opcode[w_win_idx];
            issue_prd       = r_prd[w_win_idx];
            issue_pr1       = r_pr1[w_win_idx];
            issue_pr2       = r_pr2[w_win_idx];
            issue_imm       = r_imm[w_win_idx];
            issue_rob_index = r_rob[w_win_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= '0;
            r_pr1_rdy <= '0;
            r_pr2_rdy <= '0;
            r_occ     <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_valid[i] && wb_valid && (wb_tag == r_pr1[i])) begin
                    r_pr1_rdy[i] <= 1'b1;
                end
                if (r_valid[i] && wb_valid && (wb_tag == r_pr2[i])) begin
                    r_pr2_rdy[i] <= 1'b1;
                end
                if (w_accept && r_valid[i] && (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
                if (w_fire && (w_win_idx == AGE_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                // The allocated slot was free in registered state, so it never collides with the issuing slot.
                if (w_accept && (w_free_idx == AGE_W'(i))) begin
                    r_valid[i]   <= 1'b1;
                    r_opcode[i]  <= disp_opcode;
                    r_prd[i]     <= disp_prd;
                    r_pr1[i]     <= disp_pr1;
                    r_pr2[i]     <= disp_pr2;
                    r_pr1_rdy[i] <= w_new_rdy1;
                    r_pr2_rdy[i] <= w_new_rdy2;
                    r_imm[i]     <= disp_imm;
                    r_rob[i]     <= disp_rob_index;
                    r_age[i]     <= '0;
                end
            end
            case ({w_accept, w_fire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - self-checking bench for rs_issue_scheduler
module tb_rs_issue_scheduler;

    localparam int D  = 8;
    localparam int PW = 7;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, disp_valid, disp_ready;
    logic [6:0]    disp_opcode;
    logic [PW-1:0] disp_prd, disp_pr1, disp_pr2;
    logic          disp_pr1_ready, disp_pr2_ready;
    logic [31:0]   disp_imm;
    logic [RW-1:0] disp_rob_index;
    logic          wb_valid;
    logic [PW-1:0] wb_tag;
    logic          issue_valid, issue_ready;
    logic [6:0]    issue_opcode;
    logic [PW-1:0] issue_prd, issue_pr1, issue_pr2;
    logic [31:0]   issue_imm;
    logic [RW-1:0] issue_rob_index;
    logic [3:0]    occupancy;

    rs_issue_scheduler #(.RS_DEPTH(D), .PREG_W(PW), .ROB_W(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_prd(disp_prd),
        .disp_pr1(disp_pr1), .disp_pr2(disp_pr2),
        .disp_pr1_ready(disp_pr1_ready), .disp_pr2_ready(disp_pr2_ready),
        .disp_imm(disp_imm), .disp_rob_index(disp_rob_index),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_prd(issue_prd),
        .issue_pr1(issue_pr1), .issue_pr2(issue_pr2),
        .issue_imm(issue_imm), .issue_rob_index(issue_rob_index),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: one record per slot, age as a plain integer; selection is "oldest ready".
    bit            m_valid [D];
    bit            m_r1 [D];
    bit            m_r2 [D];
    int            m_age [D];
    logic [6:0]    m_op [D];
    logic [PW-1:0] m_prd [D];
    logic [PW-1:0] m_pr1 [D];
    logic [PW-1:0] m_pr2 [D];
    logic [31:0]   m_imm [D];
    logic [RW-1:0] m_rob [D];
    int            m_occ;

    bit p_iv;
    int p_w;

    typedef struct {
        bit            dv;
        logic [RW-1:0] rob;
        bit            ir;
        bit            e_iv;
        logic [RW-1:0] e_rob;
        int            e_occ;
        bit            e_dr;
    } vec_t;
    vec_t tab [18];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit op_ready(input bit rdy, input logic [PW-1:0] tag);
`ifdef RS_WAKEUP_BYPASS_EN
        return rdy || (wb_valid && wb_tag == tag);
`else
        return rdy;
`endif
    endfunction

    task automatic model_pick(output bit found, output int w);
        int best;
        found = 0;
        w     = 0;
        best  = -1;
        for (int i = 0; i < D; i++) begin
            if (m_valid[i] && op_ready(m_r1[i], m_pr1[i]) && op_ready(m_r2[i], m_pr2[i]) && m_age[i] > best) begin
                found = 1;
                w     = i;
                best  = m_age[i];
            end
        end
    endtask

    task automatic model_clear(input bit ages);
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 0;
            if (ages) begin
                m_age[i] = 0;
                m_r1[i]  = 0;
                m_r2[i]  = 0;
            end
        end
        m_occ = 0;
    endtask

    task automatic clear_inputs();
        reset = 0; flush = 0; disp_valid = 0; disp_opcode = '0; disp_prd = '0;
        disp_pr1 = '0; disp_pr2 = '0; disp_pr1_ready = 0; disp_pr2_ready = 0;
        disp_imm = '0; disp_rob_index = '0; wb_valid = 0; wb_tag = '0; issue_ready = 0;
    endtask

    task automatic cycle_pre();
        bit f;
        logic [63:0] exp_data;
        @(negedge clk);
        model_pick(f, p_w);
        p_iv = f && !flush;
        exp_data = p_iv ? {m_op[p_w], m_prd[p_w], m_pr1[p_w], m_pr2[p_w], m_imm[p_w], m_rob[p_w]} : 64'd0;
        chk("issue_valid", 128'(issue_valid), 128'(p_iv));
        chk("issue_data", 128'({issue_opcode, issue_prd, issue_pr1, issue_pr2, issue_imm, issue_rob_index}), 128'(exp_data));
        chk("occupancy", 128'(occupancy), 128'(m_occ));
        chk("disp_ready", 128'(disp_ready), 128'(m_occ < D));
    endtask

    task automatic cycle_post();
        bit acc, fire;
        int slot;
        if (reset) begin
            model_clear(1);
        end else if (flush) begin
            model_clear(0);
        end else begin
            acc  = disp_valid && (m_occ < D);
            fire = p_iv && issue_ready;
            slot = -1;
            for (int i = D - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
            for (int i = 0; i < D; i++) begin
                if (m_valid[i] && wb_valid && wb_tag == m_pr1[i]) m_r1[i] = 1;
                if (m_valid[i] && wb_valid && wb_tag == m_pr2[i]) m_r2[i] = 1;
                if (acc && m_valid[i] && m_age[i] < D - 1) m_age[i]++;
            end
            if (fire) m_valid[p_w] = 0;
            if (acc) begin
                m_valid[slot] = 1;
                m_age[slot]   = 0;
                m_op[slot]    = disp_opcode;
                m_prd[slot]   = disp_prd;
                m_pr1[slot]   = disp_pr1;
                m_pr2[slot]   = disp_pr2;
                m_imm[slot]   = disp_imm;
                m_rob[slot]   = disp_rob_index;
                m_r1[slot]    = disp_pr1_ready || disp_pr1 == 0 || (wb_valid && wb_tag == disp_pr1);
                m_r2[slot]    = disp_pr2_ready || disp_pr2 == 0 || (wb_valid && wb_tag == disp_pr2);
            end
            m_occ = m_occ + int'(acc) - int'(fire);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        cycle_pre();
        cycle_post();
    endtask

    task automatic dispatch_ready(input logic [RW-1:0] rob);
        disp_valid = 1; disp_rob_index = rob; disp_opcode = 7'(rob) + 7'h40;
        disp_imm = 32'h1000 + 32'(rob); disp_prd = 7'(rob) + 7'd8;
        disp_pr1 = '0; disp_pr2 = '0; disp_pr1_ready = 1; disp_pr2_ready = 1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tab[i] = '{1'b1, 4'(i), 1'b0, (i > 0), 4'd0, i, 1'b1};
        tab[8] = '{1'b1, 4'd15, 1'b0, 1'b1, 4'd0, 8, 1'b0};
        for (int k = 0; k < 8; k++) tab[9 + k] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'(k), 8 - k, (k > 0)};
        tab[17] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 0, 1'b1};

        clear_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        model_clear(1);
        cycle();
        reset = 0;
        cycle();
        chk("reset_occ", 128'(occupancy), 128'd0);
        chk("reset_issue_valid", 128'(issue_valid), 128'd0);

        // Fill to full, refuse a ninth, then drain in age order.
        for (int r = 0; r < 18; r++) begin
            clear_inputs();
            if (tab[r].dv) dispatch_ready(tab[r].rob);
            issue_ready = tab[r].ir;
            cycle_pre();
            chk($sformatf("tab%0d_iv", r), 128'(issue_valid), 128'(tab[r].e_iv));
            if (tab[r].e_iv) chk($sformatf("tab%0d_rob", r), 128'(issue_rob_index), 128'(tab[r].e_rob));
            chk($sformatf("tab%0d_occ", r), 128'(occupancy), 128'(tab[r].e_occ));
            chk($sformatf("tab%0d_dr", r), 128'(disp_ready), 128'(tab[r].e_dr));
            cycle_post();
        end

        // A waits on p20, B ready -> B first; then wakeup latency.
        clear_inputs();
        disp_valid = 1; disp_opcode = 7'h11; disp_prd = 7'd5; disp_pr1 = 7'd20; disp_rob_index = 4'd1;
        cycle();
        clear_inputs();
        disp_valid = 1; disp_opcode = 7'h12; disp_prd = 7'd6; disp_pr1 = 7'd3; disp_pr1_ready = 1; disp_rob_index = 4'd2;
        cycle();
        clear_inputs();
        issue_ready = 1;
        cycle_pre();
        chk("b_issues_first", 128'({issue_valid, issue_rob_index}), 128'({1'b1, 4'd2}));
        cycle_post();
        wb_valid = 1; wb_tag = 7'd20;
        cycle_pre();
`ifdef RS_WAKEUP_BYPASS_EN
        chk("wakeup_t", 128'({issue_valid, issue_rob_index}), 128'({1'b1, 4'd1}));
`else
        chk("wakeup_t", 128'({issue_valid, issue_rob_index}), 128'({1'b0, 4'd0}));
`endif
        cycle_post();
        wb_valid = 0;
        cycle_pre();
`ifdef RS_WAKEUP_BYPASS_EN
        chk("wakeup_t1", 128'({issue_valid, issue_rob_index}), 128'({1'b0, 4'd0}));
`else
        chk("wakeup_t1", 128'({issue_valid, issue_rob_index}), 128'({1'b1, 4'd1}));
`endif
        cycle_post();
        cycle();

        // Writeback in the dispatch cycle captures the operand as ready.
        clear_inputs();
        disp_valid = 1; disp_pr2 = 7'd35; disp_rob_index = 4'd3; disp_opcode = 7'h21;
        wb_valid = 1; wb_tag = 7'd35;
        cycle_pre();
        chk("capture_iv_same", 128'(issue_valid), 128'd0);
        cycle_post();
        clear_inputs();
        issue_ready = 1;
        cycle_pre();
        chk("capture_next", 128'({issue_valid, issue_rob_index}), 128'({1'b1, 4'd3}));
        cycle_post();
        cycle();

        // Full RS: issue in the same cycle does not free a slot for dispatch.
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            dispatch_ready(4'(k));
            cycle();
        end
        dispatch_ready(4'd9);
        issue_ready = 1;
        cycle_pre();
        chk("full_dr", 128'(disp_ready), 128'd0);
        chk("full_issue", 128'({issue_valid, issue_rob_index}), 128'({1'b1, 4'd0}));
        cycle_post();
        clear_inputs();
        cycle_pre();
        chk("full_occ_after", 128'(occupancy), 128'd7);
        chk("full_dr_after", 128'(disp_ready), 128'd1);
        cycle_post();
        issue_ready = 1;
        for (int k = 0; k < 8; k++) cycle();

        // Flush with dispatch and writeback in the same cycle.
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            dispatch_ready(4'(k + 2));
            cycle();
        end
        clear_inputs();
        flush = 1; wb_valid = 1; wb_tag = 7'd9;
        dispatch_ready(4'd12);
        issue_ready = 1;
        cycle_pre();
        chk("flush_iv", 128'(issue_valid), 128'd0);
        cycle_post();
        clear_inputs();
        issue_ready = 1;
        cycle_pre();
        chk("flush_occ", 128'(occupancy), 128'd0);
        chk("flush_dr", 128'(disp_ready), 128'd1);
        cycle_post();
        for (int k = 0; k < 3; k++) begin
            cycle_pre();
            chk("flush_no_stale", 128'(issue_valid), 128'd0);
            cycle_post();
        end

        // Random traffic against the reference.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 79) == 0);
            flush          = ($urandom_range(0, 39) == 0);
            disp_valid     = ($urandom_range(0, 9) < 6);
            disp_opcode    = 7'($urandom);
            disp_prd       = 7'($urandom_range(0, 15));
            disp_pr1       = 7'($urandom_range(0, 7));
            disp_pr2       = 7'($urandom_range(0, 7));
            disp_pr1_ready = ($urandom_range(0, 1) == 1);
            disp_pr2_ready = ($urandom_range(0, 1) == 1);
            disp_imm       = $urandom;
            disp_rob_index = 4'($urandom);
            wb_valid       = ($urandom_range(0, 2) == 0);
            wb_tag         = 7'($urandom_range(0, 7));
            issue_ready    = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
